mc_core_ctrl: RTL

Multi-cycle sequencer for the NPC core, replacing the single-cycle top's free-running PC and combinational memory paths. It owns the PC and the latched instruction register, and drives valid/ready handshakes to instruction and data memory. It gates register-file and CSR write enables into a single commit pulse and detects ebreak halt, bus errors, timeouts and misaligned redirects. It sits between the PC/IFU/LSU bus ports and the existing IDU/EXU/RegisterFile/CSR datapath.

---
 rtl/mc_core_pkg.sv | 34 +++
 rtl/mc_wait_timer.sv | 31 +++
 rtl/mc_core_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mc_core_pkg.sv
// Shared types and constants for the multi-cycle core sequencer.
// Optional performance counters in mc_core_ctrl are enabled by defining
// MC_CORE_CTRL_PERF_EN.
package mc_core_pkg;

  // Sequencer states (3-bit encoding, exported on the debug state port)
  typedef enum logic [2:0] {
    ST_FETCH_REQ  = 3'd0,
    ST_FETCH_WAIT = 3'd1,
    ST_EXEC       = 3'd2,
    ST_MEM_REQ    = 3'd3,
    ST_MEM_WAIT   = 3'd4,
    ST_COMMIT     = 3'd5,
    ST_HALT       = 3'd6,
    ST_FAULT      = 3'd7
  } state_e;

  // Reason reported on o_fault_cause once the sequencer has faulted
  typedef enum logic [1:0] {
    CAUSE_IFETCH_ERR = 2'd0,
    CAUSE_LSU_ERR    = 2'd1,
    CAUSE_TIMEOUT    = 2'd2,
    CAUSE_MISALIGN   = 2'd3
  } fault_cause_e;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
  localparam int unsigned INST_BYTES  = 4;

  // A redirect target is usable only if it is word aligned
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Wait-state watchdog shared by the fetch and data WAIT states.
// count holds the number of wait cycles already completed; o_expired is
// raised during the (2^TIMEOUT_W - 1)th wait cycle so the sequencer can
// leave for FAULT at the end of that cycle.
module mc_wait_timer #(
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [TIMEOUT_W-1:0] LAST_WAIT = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [TIMEOUT_W-1:0] ONE       = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  logic [TIMEOUT_W-1:0] count;

  // Count completed wait cycles; cleared whenever the sequencer is not waiting
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      count <= '0;
    end else if (i_enable && !o_expired) begin
      count <= count + ONE;
    end
  end

  assign o_expired = i_enable && (count == LAST_WAIT);

endmodule

// File: rtl/mc_core_ctrl.sv
// Multi-cycle sequencer for the NPC core: owns PC and instruction register,
// handshakes with instruction/data memory, gates commit write enables and
// detects ebreak halt, bus errors, wait timeouts and misaligned redirects.
// Define MC_CORE_CTRL_PERF_EN to build the mcycle/minstret counters.
//
// Handshake: a request transfers on a cycle where valid && ready are both
// high; valid is held (and the address kept stable) until that cycle. The
// response is taken on the first resp_valid seen in the matching WAIT state;
// resp_valid in any other state is ignored.
module mc_core_ctrl
  import mc_core_pkg::*;
#(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = XLEN'(32'h8000_0000),
  parameter int unsigned      TIMEOUT_W = 8
) (
  input  logic            i_clock,
  input  logic            i_reset,
  output logic            o_imem_req_valid,
  input  logic            i_imem_req_ready,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_resp_valid,
  input  logic [31:0]     i_imem_resp_data,
  input  logic            i_imem_resp_err,
  output logic [31:0]     o_inst,
  output logic [XLEN-1:0] o_pc,
  input  logic            i_ex_redirect,
  input  logic [XLEN-1:0] i_ex_upc,
  input  logic            i_ex_mem_ren,
  input  logic            i_ex_mem_wen,
  input  logic            i_ex_reg_wen,
  input  logic            i_ex_csr_wen,
  output logic            o_dmem_req_valid,
  input  logic            i_dmem_req_ready,
  input  logic            i_dmem_resp_valid,
  input  logic            i_dmem_resp_err,
  output logic            o_reg_wen,
  output logic            o_csr_wen,
  output logic            o_retire,
  output logic            o_halt,
  output logic            o_fault,
  output logic [1:0]      o_fault_cause,
  output logic [63:0]     o_mcycle,
  output logic [63:0]     o_minstret,
  output logic [2:0]      o_state
);

  localparam logic [2:0] S_FETCH_REQ  = ST_FETCH_REQ;
  localparam logic [2:0] S_FETCH_WAIT = ST_FETCH_WAIT;
  localparam logic [2:0] S_EXEC       = ST_EXEC;
  localparam logic [2:0] S_MEM_REQ    = ST_MEM_REQ;
  localparam logic [2:0] S_MEM_WAIT   = ST_MEM_WAIT;
  localparam logic [2:0] S_COMMIT     = ST_COMMIT;
  localparam logic [2:0] S_HALT       = ST_HALT;
  localparam logic [2:0] S_FAULT      = ST_FAULT;

  logic [2:0]      state, state_d;
  logic [XLEN-1:0] pc, pc_d;
  logic [31:0]     inst, inst_d;
  logic [1:0]      cause, cause_d;
  logic            in_wait;
  logic            tmr_expired;
  logic            bad_target;
  logic            commit_ok;

  assign in_wait    = (state == S_FETCH_WAIT) || (state == S_MEM_WAIT);
  assign bad_target = i_ex_redirect && is_misaligned(i_ex_upc[1:0]);
  // A misaligned redirect suppresses the whole commit: no writes, no retire
  assign commit_ok  = !i_reset && (state == S_COMMIT) && !bad_target;

  mc_wait_timer #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_wait_timer (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_clear   (!in_wait),
    .i_enable  (in_wait),
    .o_expired (tmr_expired)
  );

  // Next-state, PC, instruction latch and fault-cause selection
  always_comb begin
    state_d = state;
    pc_d    = pc;
    inst_d  = inst;
    cause_d = cause;
    case (state)
      S_FETCH_REQ: begin
        if (i_imem_req_ready) state_d = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        // A response in the timeout cycle still wins over the timeout
        if (i_imem_resp_valid) begin
          inst_d = i_imem_resp_data;
          if (i_imem_resp_err) begin
            state_d = S_FAULT;
            cause_d = CAUSE_IFETCH_ERR;
          end else begin
            state_d = S_EXEC;
          end
        end else if (tmr_expired) begin
          state_d = S_FAULT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_EXEC: begin
        if (inst == EBREAK_INST)              state_d = S_HALT;
        else if (i_ex_mem_ren || i_ex_mem_wen) state_d = S_MEM_REQ;
        else                                  state_d = S_COMMIT;
      end
      S_MEM_REQ: begin
        if (i_dmem_req_ready) state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (i_dmem_resp_valid) begin
          if (i_dmem_resp_err) begin
            state_d = S_FAULT;
            cause_d = CAUSE_LSU_ERR;
          end else begin
            state_d = S_COMMIT;
          end
        end else if (tmr_expired) begin
          state_d = S_FAULT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_COMMIT: begin
        if (bad_target) begin
          state_d = S_FAULT;
          cause_d = CAUSE_MISALIGN;
        end else begin
          pc_d    = i_ex_redirect ? i_ex_upc : pc + XLEN'(INST_BYTES);
          state_d = S_FETCH_REQ;
        end
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FETCH_REQ;
    endcase
  end

  // Sequencer registers with synchronous reset
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= S_FETCH_REQ;
      pc    <= RESET_PC;
      inst  <= '0;
      cause <= CAUSE_IFETCH_ERR;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      inst  <= inst_d;
      cause <= cause_d;
    end
  end

  assign o_imem_req_valid = !i_reset && (state == S_FETCH_REQ);
  assign o_dmem_req_valid = !i_reset && (state == S_MEM_REQ);
  assign o_imem_addr      = pc;
  assign o_pc             = pc;
  assign o_inst           = inst;
  assign o_retire         = commit_ok;
  assign o_reg_wen        = commit_ok && i_ex_reg_wen;
  assign o_csr_wen        = commit_ok && i_ex_csr_wen;
  assign o_halt           = (state == S_HALT);
  assign o_fault          = (state == S_FAULT);
  assign o_fault_cause    = cause;
  assign o_state          = state;

`ifdef MC_CORE_CTRL_PERF_EN
  logic [63:0] mcycle;
  logic [63:0] minstret;

  // Free-running cycle and retired-instruction counters, wrapping at 2^64
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle <= mcycle + 64'd1;
      if (commit_ok) minstret <= minstret + 64'd1;
    end
  end

  assign o_mcycle   = mcycle;
  assign o_minstret = minstret;
`else
  assign o_mcycle   = '0;
  assign o_minstret = '0;
`endif

endmodule
